mutual_monitor: RTL and testbench
=================================

MUTUAL_MONITOR -- requirements
Module: mutual_monitor

Interface
REQ-001 Parameter NCLIENT, default 3: number of protocol clients observed; legal range 2..4.
REQ-002 Parameter CW, default 32: width of the step and cycle counters.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 snap_valid  input  1  a new protocol state snapshot is present this cycle.
REQ-006 snap_n  input  2*NCLIENT  per-client state; client i occupies bits [2i+1:2i]; 0=I, 1=T, 2=C, 3=E.
REQ-007 snap_x  input  1  lock-free flag of the observed system.
REQ-008 err  output  1  sticky: a protocol violation has been detected.
REQ-009 err_code  output  3  first violation code; 0=none, 1=MUTEX, 2=ILLEGAL_TRANS, 3=MULTI_STEP, 4=X_INCONSISTENT.
REQ-010 err_client  output  2  lowest-index client implicated in the first violation; 0 for code 3 and code 4.
REQ-011 err_step  output  CW  value of step_count at the snapshot that failed.
REQ-012 step_count  output  CW  number of accepted snapshots since reset, saturating at all-ones.
REQ-013 crit_count  output  CW  number of observed T->C transitions, saturating at all-ones.

Function
REQ-014 The FSM SHALL have three states: EMPTY (no previous snapshot), RUN, FAIL.
REQ-015 EMPTY + snap_valid: check MUTEX and X_INCONSISTENT only, store snapshot, increment step_count, go to RUN, or go to FAIL if a check fails.
REQ-016 RUN + snap_valid: run all four checks against the stored previous snapshot, store the new snapshot, increment step_count, stay in RUN, or go to FAIL on any violation.
REQ-017 MUTEX SHALL fire when more than one client is in C.
REQ-018 ILLEGAL_TRANS SHALL fire when any client changes state other than I->T, T->C, C->E or E->I.
REQ-019 MULTI_STEP SHALL fire when more than one client changes state between consecutive snapshots.
REQ-020 X_INCONSISTENT SHALL fire when snap_x differs from (no client in C or E).
REQ-021 An unchanged snapshot (stutter) SHALL be legal; it still increments step_count.
REQ-022 Simultaneous violations SHALL report the lowest err_code; err_client SHALL be the lowest implicated index.
REQ-023 err, err_code, err_client and err_step SHALL update in the cycle after the failing snapshot (1-cycle latency) and SHALL then hold.
REQ-024 In FAIL, snapshots SHALL be ignored: no counter or error-field updates; only reset leaves FAIL.
REQ-025 snap_valid low SHALL change no state.
REQ-026 crit_count SHALL increment once per client per accepted snapshot that shows a T->C transition, including the failing snapshot.
REQ-027 Counters SHALL saturate at 2^CW-1 and SHALL NOT wrap.

Reset
REQ-028 While reset is low at a rising edge: FSM=EMPTY; err=0, err_code=0, err_client=0, err_step=0, step_count=0, crit_count=0; stored snapshot cleared to all-I.
REQ-029 Reset asserted mid-run SHALL discard the stored snapshot; the next snapshot SHALL be treated as the first.

Structure
REQ-030 A shared package SHALL hold the client-state encodings (I, T, C, E), the err_code constants and the FSM state type.
REQ-031 A sub-module mutual_trans_chk SHALL classify one client's previous/current state pair (changed, legal, entered_crit); mutual_monitor SHALL instantiate it NCLIENT times.

Verification
REQ-032 Reset, then snapshots n=(I,I,I),x=1 -> (T,I,I),x=1 -> (C,I,I),x=0 -> (E,I,I),x=0 -> (I,I,I),x=1 -> err=0, step_count=5, crit_count=1.
REQ-033 From (C,T,I),x=0 apply (C,C,I),x=0 -> err=1, err_code=1, err_client=0, err_step=1.
REQ-034 From (I,I,I),x=1 apply (C,I,I),x=0 -> err_code=2, err_client=0; later snapshots leave all error fields and counters unchanged.
REQ-035 From (I,I,I),x=1 apply (T,T,I),x=1 -> err_code=3, err_client=0; first snapshot (I,I,I),x=0 -> err_code=4.
REQ-036 Preload step_count to all-ones minus 1, apply 3 legal snapshots -> step_count holds at all-ones; pulse reset low mid-run -> all outputs 0, FSM in EMPTY.

Source files
------------

// File: rtl/mutual_monitor_pkg.sv
// Shared definitions for the mutual-exclusion protocol monitor.
//   client_st_e  : per-client protocol state encoding (I, T, C, E)
//   ERR_*        : first-violation codes reported on err_code
//   fsm_state_e  : monitor FSM states
package mutual_monitor_pkg;

    typedef enum logic [1:0] {
        CL_I = 2'd0,
        CL_T = 2'd1,
        CL_C = 2'd2,
        CL_E = 2'd3
    } client_st_e;

    localparam logic [2:0] ERR_NONE           = 3'd0;
    localparam logic [2:0] ERR_MUTEX          = 3'd1;
    localparam logic [2:0] ERR_ILLEGAL_TRANS  = 3'd2;
    localparam logic [2:0] ERR_MULTI_STEP     = 3'd3;
    localparam logic [2:0] ERR_X_INCONSISTENT = 3'd4;

    typedef enum logic [1:0] {
        FSM_EMPTY = 2'd0,
        FSM_RUN   = 2'd1,
        FSM_FAIL  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/mutual_trans_chk.sv
// Classifies one client's previous/current state pair.
//   prev_i, cur_i     : client state in the stored and the new snapshot
//   changed_o         : state differs between the two snapshots
//   legal_o           : no change, or one of I->T, T->C, C->E, E->I
//   entered_crit_o    : the pair is a T->C transition
module mutual_trans_chk
    import mutual_monitor_pkg::*;
(
    input  logic [1:0] prev_i,
    input  logic [1:0] cur_i,
    output logic       changed_o,
    output logic       legal_o,
    output logic       entered_crit_o
);

    assign changed_o      = (prev_i != cur_i);
    // The legal cycle I->T->C->E->I is exactly "advance by one" in the
    // 2-bit encoding, wrapping E back to I.
    assign legal_o        = !changed_o || (cur_i == prev_i + 2'd1);
    assign entered_crit_o = (prev_i == CL_T) && (cur_i == CL_C);

endmodule

// File: rtl/mutual_monitor.sv
// Runtime monitor for a mutual-exclusion protocol with NCLIENT clients.
//   clock, reset          : clock and synchronous active-low reset
//   snap_valid/n/x        : snapshot strobe, packed client states, lock-free flag
//   err/err_code/err_client/err_step : sticky first-violation report
//   step_count/crit_count : accepted snapshots and T->C transitions (saturating)
module mutual_monitor
    import mutual_monitor_pkg::*;
#(
    parameter int NCLIENT = 3,
    parameter int CW      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   snap_valid,
    input  logic [2*NCLIENT-1:0]   snap_n,
    input  logic                   snap_x,
    output logic                   err,
    output logic [2:0]             err_code,
    output logic [1:0]             err_client,
    output logic [CW-1:0]          err_step,
    output logic [CW-1:0]          step_count,
    output logic [CW-1:0]          crit_count
);

    fsm_state_e           state_q;
    logic [2*NCLIENT-1:0] prev_q;
    logic                 err_q;
    logic [2:0]           code_q;
    logic [1:0]           client_q;
    logic [CW-1:0]        estep_q;
    logic [CW-1:0]        step_q;
    logic [CW-1:0]        crit_q;

    logic [NCLIENT-1:0]   changed;
    logic [NCLIENT-1:0]   legal;
    logic [NCLIENT-1:0]   entered;

    for (genvar g = 0; g < NCLIENT; g++) begin : g_chk
        mutual_trans_chk u_chk (
            .prev_i         (prev_q[2*g +: 2]),
            .cur_i          (snap_n[2*g +: 2]),
            .changed_o      (changed[g]),
            .legal_o        (legal[g]),
            .entered_crit_o (entered[g])
        );
    end

    logic [2:0]    n_in_c, n_chg, n_tc;
    logic          any_ce, any_illegal;
    logic [1:0]    mutex_cl, illegal_cl;
    logic          run;
    logic [2:0]    code_d;
    logic [1:0]    client_d;
    logic [CW-1:0] step_d;
    logic [CW:0]   crit_sum;
    logic [CW-1:0] crit_d;

    always_comb begin
        n_in_c      = '0;
        n_chg       = '0;
        n_tc        = '0;
        any_ce      = 1'b0;
        any_illegal = 1'b0;
        mutex_cl    = '0;
        illegal_cl  = '0;
        // Walk downwards so the last hit recorded is the lowest index.
        for (int i = NCLIENT - 1; i >= 0; i--) begin
            if (snap_n[2*i +: 2] == CL_C) begin
                n_in_c   = n_in_c + 3'd1;
                mutex_cl = 2'(i);
            end
            if (snap_n[2*i +: 2] == CL_C || snap_n[2*i +: 2] == CL_E) begin
                any_ce = 1'b1;
            end
            if (changed[i]) begin
                n_chg = n_chg + 3'd1;
            end
            if (!legal[i]) begin
                any_illegal = 1'b1;
                illegal_cl  = 2'(i);
            end
            if (entered[i]) begin
                n_tc = n_tc + 3'd1;
            end
        end

        // Transition checks need a real previous snapshot, so only in RUN.
        run      = (state_q == FSM_RUN);
        code_d   = ERR_NONE;
        client_d = '0;
        if (n_in_c > 3'd1) begin
            code_d   = ERR_MUTEX;
            client_d = mutex_cl;
        end else if (run && any_illegal) begin
            code_d   = ERR_ILLEGAL_TRANS;
            client_d = illegal_cl;
        end else if (run && n_chg > 3'd1) begin
            code_d   = ERR_MULTI_STEP;
        end else if (snap_x != !any_ce) begin
            code_d   = ERR_X_INCONSISTENT;
        end

        step_d   = (step_q == '1) ? step_q : step_q + CW'(1);
        crit_sum = {1'b0, crit_q} + (CW+1)'(n_tc);
        crit_d   = crit_sum[CW] ? '1 : crit_sum[CW-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= FSM_EMPTY;
            prev_q   <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            client_q <= '0;
            estep_q  <= '0;
            step_q   <= '0;
            crit_q   <= '0;
        end else if (snap_valid) begin
            case (state_q)
                FSM_EMPTY, FSM_RUN: begin
                    prev_q <= snap_n;
                    step_q <= step_d;
                    crit_q <= crit_d;
                    if (code_d != ERR_NONE) begin
                        state_q  <= FSM_FAIL;
                        err_q    <= 1'b1;
                        code_q   <= code_d;
                        client_q <= client_d;
                        // Report the count as it stood when the bad snapshot arrived.
                        estep_q  <= step_q;
                    end else begin
                        state_q  <= FSM_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err        = err_q;
    assign err_code   = code_q;
    assign err_client = client_q;
    assign err_step   = estep_q;
    assign step_count = step_q;
    assign crit_count = crit_q;

endmodule

// File: tb/tb_mutual_monitor.sv
module tb_mutual_monitor;

    localparam int N    = 3;
    localparam int CW   = 6;
    localparam int MAXV = 63;
    localparam int I = 0, T = 1, C = 2, E = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          snap_valid = 1'b0;
    logic [2*N-1:0] snap_n = '0;
    logic          snap_x = 1'b0;
    logic          err;
    logic [2:0]    err_code;
    logic [1:0]    err_client;
    logic [CW-1:0] err_step, step_count, crit_count;

    int tests = 0;
    int fails = 0;

    mutual_monitor #(.NCLIENT(N), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .snap_valid (snap_valid),
        .snap_n     (snap_n),
        .snap_x     (snap_x),
        .err        (err),
        .err_code   (err_code),
        .err_client (err_client),
        .err_step   (err_step),
        .step_count (step_count),
        .crit_count (crit_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rb;
        logic       v;
        logic [5:0] n;
        logic       x;
        int         e, code, cl, es, sc, cc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [5:0] sn(int a, int b, int c);
        return {c[1:0], b[1:0], a[1:0]};
    endfunction

    function automatic vec_t mk(logic rb, logic v, logic [5:0] n, logic x,
                                int e, int code, int cl, int es, int sc, int cc);
        vec_t r;
        r.rb = rb; r.v = v; r.n = n; r.x = x;
        r.e = e; r.code = code; r.cl = cl; r.es = es; r.sc = sc; r.cc = cc;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic rb, logic v, logic [5:0] n, logic x);
        reset = rb; snap_valid = v; snap_n = n; snap_x = x;
        @(posedge clock);
        #1;
        snap_valid = 1'b0;
    endtask

    task automatic chk_all(string tag, int e, int code, int cl, int es, int sc, int cc);
        chk({tag, ".err"},        int'(err),        e);
        chk({tag, ".err_code"},   int'(err_code),   code);
        chk({tag, ".err_client"}, int'(err_client), cl);
        chk({tag, ".err_step"},   int'(err_step),   es);
        chk({tag, ".step_count"}, int'(step_count), sc);
        chk({tag, ".crit_count"}, int'(crit_count), cc);
    endtask

    // Reference model: tracks the protocol abstractly as integer client states.
    bit m_has_prev, m_fail;
    int m_prev[N];
    int m_step, m_crit, m_err, m_code, m_cl, m_es;

    task automatic model_step(logic rb, logic v, logic [5:0] n, logic x);
        int cur[N];
        int nc, nchg, ntc, code, cl, first_c, first_bad;
        bit ce;
        if (!rb) begin
            m_has_prev = 0; m_fail = 0;
            foreach (m_prev[i]) m_prev[i] = I;
            m_step = 0; m_crit = 0; m_err = 0; m_code = 0; m_cl = 0; m_es = 0;
            return;
        end
        if (!v || m_fail) return;
        nc = 0; nchg = 0; ntc = 0; ce = 0; first_c = -1; first_bad = -1;
        for (int i = 0; i < N; i++) begin
            cur[i] = int'(n[2*i +: 2]);
            if (cur[i] == C) begin
                nc++;
                if (first_c < 0) first_c = i;
            end
            if (cur[i] == C || cur[i] == E) ce = 1;
            if (cur[i] != m_prev[i]) begin
                nchg++;
                if ((cur[i] - m_prev[i] + 4) % 4 != 1 && first_bad < 0) first_bad = i;
            end
            if (m_prev[i] == T && cur[i] == C) ntc++;
        end
        code = 0; cl = 0;
        if (x != !ce) begin code = 4; cl = 0; end
        if (m_has_prev && nchg > 1) begin code = 3; cl = 0; end
        if (m_has_prev && first_bad >= 0) begin code = 2; cl = first_bad; end
        if (nc > 1) begin code = 1; cl = first_c; end
        if (code != 0) begin
            m_fail = 1; m_err = 1; m_code = code; m_cl = cl; m_es = m_step;
        end
        m_step = (m_step + 1 > MAXV) ? MAXV : m_step + 1;
        m_crit = (m_crit + ntc > MAXV) ? MAXV : m_crit + ntc;
        foreach (m_prev[i]) m_prev[i] = cur[i];
        m_has_prev = 1;
    endtask

    int gen[N];

    initial begin
        // ---- table-driven directed vectors ----
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(T,I,I), 1, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, sn(C,I,I), 0, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(1, 1, sn(E,I,I), 0, 0, 0, 0, 0, 4, 1));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(1, 0, sn(C,C,C), 0, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 6, 1));
        // mutex, T->C of client 1 still counted
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(C,T,I), 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(C,C,I), 0, 1, 1, 0, 1, 2, 1));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 1, 1, 0, 1, 2, 1));
        // illegal transition, then ignored snapshots
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(C,I,I), 0, 1, 2, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, sn(T,I,I), 1, 1, 2, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, sn(C,I,I), 0, 1, 2, 0, 1, 2, 0));
        // multi-step
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(T,T,I), 1, 1, 3, 0, 1, 2, 0));
        // x inconsistent on the first snapshot
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,I,I), 0, 1, 4, 0, 0, 1, 0));
        // illegal on client 2
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,I,I), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(I,I,C), 0, 1, 2, 2, 1, 2, 0));
        // mutex among clients 1,2 with wrong x: lowest code and index win
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(I,C,C), 1, 1, 1, 1, 0, 1, 0));
        // illegal on client 1 and multi-step together: illegal wins
        tbl.push_back(mk(0, 0, sn(I,I,I), 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, sn(T,I,I), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, sn(C,E,I), 0, 1, 2, 1, 1, 2, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rb, tbl[k].v, tbl[k].n, tbl[k].x);
            chk_all($sformatf("vec%0d", k), tbl[k].e, tbl[k].code, tbl[k].cl,
                    tbl[k].es, tbl[k].sc, tbl[k].cc);
        end

        // ---- step_count saturation then mid-run reset ----
        drive(0, 0, sn(I,I,I), 0);
        for (int k = 0; k < MAXV - 1; k++) drive(1, 1, sn(I,I,I), 1);
        chk_all("sat_pre", 0, 0, 0, 0, MAXV - 1, 0);
        drive(1, 1, sn(T,I,I), 1);
        chk_all("sat_1", 0, 0, 0, 0, MAXV, 0);
        drive(1, 1, sn(C,I,I), 0);
        chk_all("sat_2", 0, 0, 0, 0, MAXV, 1);
        drive(1, 1, sn(E,I,I), 0);
        chk_all("sat_3", 0, 0, 0, 0, MAXV, 1);
        drive(0, 1, sn(I,I,I), 1);
        chk_all("midrst", 0, 0, 0, 0, 0, 0);
        // (C,I,I) would be illegal after (E,I,I); legal only as a first snapshot
        drive(1, 1, sn(C,I,I), 0);
        chk_all("post_rst", 0, 0, 0, 0, 1, 0);

        // ---- randomized runs against the reference model ----
        for (int run = 0; run < 6; run++) begin
            int len;
            bit inject;
            inject = (run != 5);
            len = inject ? 120 : 400;
            drive(0, 0, sn(I,I,I), 0);
            model_step(0, 0, sn(I,I,I), 0);
            foreach (gen[i]) gen[i] = I;
            for (int s = 0; s < len; s++) begin
                logic [5:0] n;
                logic x, v;
                bit ce;
                int r, k;
                v = ($urandom_range(0, 9) != 0);
                r = $urandom_range(0, 99);
                if (inject && r >= 95) begin
                    for (int i = 0; i < N; i++) gen[i] = $urandom_range(0, 3);
                end else if (r >= 15) begin
                    k = $urandom_range(0, N - 1);
                    if (gen[k] == T)
                        for (int j = 0; j < N; j++) if (gen[j] == C) k = j;
                    gen[k] = (gen[k] + 1) % 4;
                end
                ce = 0;
                for (int i = 0; i < N; i++) if (gen[i] == C || gen[i] == E) ce = 1;
                x = !ce;
                if (inject && $urandom_range(0, 99) < 3) x = !x;
                n = sn(gen[0], gen[1], gen[2]);
                drive(1, v, n, x);
                model_step(1, v, n, x);
                chk_all($sformatf("rand%0d_%0d", run, s), m_err, m_code, m_cl,
                        m_es, m_step, m_crit);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
